// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU datapath constants.
//   WORD_W        : datapath word width
//   BUS_SEL_W     : width of the bus source select code
//   SEL_*         : named select codes for every bus source
//   SEL_MAX_VALID : highest mapped select code
//   sel_unmapped(): flags select codes that have no source behind them
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int WORD_W    = 32;
  localparam int BUS_SEL_W = 5;

  typedef logic [BUS_SEL_W-1:0] bus_sel_t;

  localparam bus_sel_t SEL_R0        = 5'd0;
  localparam bus_sel_t SEL_R1        = 5'd1;
  localparam bus_sel_t SEL_R2        = 5'd2;
  localparam bus_sel_t SEL_R3        = 5'd3;
  localparam bus_sel_t SEL_R4        = 5'd4;
  localparam bus_sel_t SEL_R5        = 5'd5;
  localparam bus_sel_t SEL_R6        = 5'd6;
  localparam bus_sel_t SEL_R7        = 5'd7;
  localparam bus_sel_t SEL_R8        = 5'd8;
  localparam bus_sel_t SEL_R9        = 5'd9;
  localparam bus_sel_t SEL_R10       = 5'd10;
  localparam bus_sel_t SEL_R11       = 5'd11;
  localparam bus_sel_t SEL_R12       = 5'd12;
  localparam bus_sel_t SEL_R13       = 5'd13;
  localparam bus_sel_t SEL_R14       = 5'd14;
  localparam bus_sel_t SEL_R15       = 5'd15;
  localparam bus_sel_t SEL_HI        = 5'd16;
  localparam bus_sel_t SEL_LO        = 5'd17;
  localparam bus_sel_t SEL_ZHI       = 5'd18;
  localparam bus_sel_t SEL_ZLO       = 5'd19;
  localparam bus_sel_t SEL_PC        = 5'd20;
  localparam bus_sel_t SEL_MDR       = 5'd21;
  localparam bus_sel_t SEL_INPORT    = 5'd22;
  localparam bus_sel_t SEL_CSEXT     = 5'd23;
  localparam bus_sel_t SEL_MAX_VALID = 5'd23;

  // True when the code selects nothing (24..31).
  function automatic logic sel_unmapped(input bus_sel_t code);
    return (code > SEL_MAX_VALID);
  endfunction

endpackage : cpu_pkg

// File: rtl/bus_mux_if.sv
// ----------------------------------------------------------------------------
// bus_mux_if
// Groups every bus source, the select code and the registered bus outputs.
//   r0_in..r15_in, hi_in, lo_in, zhi_in, zlo_in, pc_in, mdr_in, inport_in,
//   c_sext_in : source words (WIDTH each)
//   sel       : source select code (SEL_W)
//   bus_out   : registered bus value (WIDTH)
//   sel_err   : registered unmapped-select flag
// Modports:
//   master : datapath/control side, drives sources and sel, reads the bus
//   slave  : the multiplexer, reads sources and sel, drives the bus
// ----------------------------------------------------------------------------
interface bus_mux_if #(
  parameter int WIDTH = cpu_pkg::WORD_W,
  parameter int SEL_W = cpu_pkg::BUS_SEL_W
);

  logic [WIDTH-1:0] r0_in;
  logic [WIDTH-1:0] r1_in;
  logic [WIDTH-1:0] r2_in;
  logic [WIDTH-1:0] r3_in;
  logic [WIDTH-1:0] r4_in;
  logic [WIDTH-1:0] r5_in;
  logic [WIDTH-1:0] r6_in;
  logic [WIDTH-1:0] r7_in;
  logic [WIDTH-1:0] r8_in;
  logic [WIDTH-1:0] r9_in;
  logic [WIDTH-1:0] r10_in;
  logic [WIDTH-1:0] r11_in;
  logic [WIDTH-1:0] r12_in;
  logic [WIDTH-1:0] r13_in;
  logic [WIDTH-1:0] r14_in;
  logic [WIDTH-1:0] r15_in;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;
  logic [WIDTH-1:0] zhi_in;
  logic [WIDTH-1:0] zlo_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] mdr_in;
  logic [WIDTH-1:0] inport_in;
  logic [WIDTH-1:0] c_sext_in;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] bus_out;
  logic             sel_err;

  modport master (
    output r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in,
    output r8_in, r9_in, r10_in, r11_in, r12_in, r13_in, r14_in, r15_in,
    output hi_in, lo_in, zhi_in, zlo_in, pc_in, mdr_in, inport_in, c_sext_in,
    output sel,
    input  bus_out, sel_err
  );

  modport slave (
    input  r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in,
    input  r8_in, r9_in, r10_in, r11_in, r12_in, r13_in, r14_in, r15_in,
    input  hi_in, lo_in, zhi_in, zlo_in, pc_in, mdr_in, inport_in, c_sext_in,
    input  sel,
    output bus_out, sel_err
  );

endinterface : bus_mux_if

// File: rtl/bus_mux.sv
// ----------------------------------------------------------------------------
// bus_mux
// 24-source datapath bus multiplexer with one registered output stage.
// Ports:
//   clock : system clock, all updates on the rising edge
//   clear : synchronous active-high reset (bus_out and sel_err to 0)
//   bus   : bus_mux_if.slave -- sources, sel in; bus_out, sel_err out
// A full case over all 32 select codes feeds the output register, so there is
// no combinational path from any input to bus_out or sel_err. Unmapped codes
// (24..31) load zero and raise sel_err for that cycle.
// ----------------------------------------------------------------------------
module bus_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SEL_W = BUS_SEL_W
) (
  input  logic       clock,
  input  logic       clear,
  bus_mux_if.slave   bus
);

  logic [WIDTH-1:0] mux_s;
  logic             sel_bad_s;
  logic [WIDTH-1:0] bus_out_r;
  logic             sel_err_r;

  // Source select: every code has an arm, unmapped codes drive zero.
  always_comb begin
    mux_s     = {WIDTH{1'b0}};
    sel_bad_s = 1'b0;
    case (bus.sel)
      SEL_R0:     mux_s = bus.r0_in;
      SEL_R1:     mux_s = bus.r1_in;
      SEL_R2:     mux_s = bus.r2_in;
      SEL_R3:     mux_s = bus.r3_in;
      SEL_R4:     mux_s = bus.r4_in;
      SEL_R5:     mux_s = bus.r5_in;
      SEL_R6:     mux_s = bus.r6_in;
      SEL_R7:     mux_s = bus.r7_in;
      SEL_R8:     mux_s = bus.r8_in;
      SEL_R9:     mux_s = bus.r9_in;
      SEL_R10:    mux_s = bus.r10_in;
      SEL_R11:    mux_s = bus.r11_in;
      SEL_R12:    mux_s = bus.r12_in;
      SEL_R13:    mux_s = bus.r13_in;
      SEL_R14:    mux_s = bus.r14_in;
      SEL_R15:    mux_s = bus.r15_in;
      SEL_HI:     mux_s = bus.hi_in;
      SEL_LO:     mux_s = bus.lo_in;
      SEL_ZHI:    mux_s = bus.zhi_in;
      SEL_ZLO:    mux_s = bus.zlo_in;
      SEL_PC:     mux_s = bus.pc_in;
      SEL_MDR:    mux_s = bus.mdr_in;
      SEL_INPORT: mux_s = bus.inport_in;
      SEL_CSEXT:  mux_s = bus.c_sext_in;
      default:    mux_s = {WIDTH{1'b0}};
    endcase
    sel_bad_s = sel_unmapped(bus.sel);
  end

  // Output register stage; clear wins over any pending selection.
  always_ff @(posedge clock) begin
    if (clear) begin
      bus_out_r <= {WIDTH{1'b0}};
      sel_err_r <= 1'b0;
    end else begin
      bus_out_r <= mux_s;
      sel_err_r <= sel_bad_s;
    end
  end

  assign bus.bus_out = bus_out_r;
  assign bus.sel_err = sel_err_r;

endmodule : bus_mux

// File: tb/tb_bus_mux.sv
// ----------------------------------------------------------------------------
// tb_bus_mux
// Directed self-checking bench for bus_mux. Inputs change 1 time unit after
// the rising edge; outputs are sampled at that same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_bus_mux;

  logic clock;
  logic clear;
  int   n_cmp;
  int   n_err;

  bus_mux_if bif ();

  bus_mux dut (
    .clock (clock),
    .clear (clear),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive the source behind select code 'code'.
  task automatic set_src(input int code, input logic [31:0] v);
    case (code)
      0:  bif.r0_in     = v;
      1:  bif.r1_in     = v;
      2:  bif.r2_in     = v;
      3:  bif.r3_in     = v;
      4:  bif.r4_in     = v;
      5:  bif.r5_in     = v;
      6:  bif.r6_in     = v;
      7:  bif.r7_in     = v;
      8:  bif.r8_in     = v;
      9:  bif.r9_in     = v;
      10: bif.r10_in    = v;
      11: bif.r11_in    = v;
      12: bif.r12_in    = v;
      13: bif.r13_in    = v;
      14: bif.r14_in    = v;
      15: bif.r15_in    = v;
      16: bif.hi_in     = v;
      17: bif.lo_in     = v;
      18: bif.zhi_in    = v;
      19: bif.zlo_in    = v;
      20: bif.pc_in     = v;
      21: bif.mdr_in    = v;
      22: bif.inport_in = v;
      23: bif.c_sext_in = v;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bif.sel = 5'd3;
    set_src(3, 32'd145);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bif.bus_out !== 32'd0 || bif.sel_err !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: bus_out=%h sel_err=%b, required 00000000/0",
                 i, bif.bus_out, bif.sel_err);
      end
    end
    clear = 1'b0;
    tick();
    n_cmp++;
    if (bif.bus_out !== 32'd145 || bif.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: bus_out=%0d sel_err=%b, required 145/0",
               bif.bus_out, bif.sel_err);
    end
  endtask

  task automatic test_registers();
    logic [31:0] vals [6];
    vals = '{32'd0, 32'd20, 32'd100, 32'd145, 32'd0, 32'd243};
    for (int i = 0; i < 6; i++) set_src(i, vals[i]);
    // Distinct values on the remaining registers to catch wrong-arm selects.
    for (int i = 6; i < 16; i++) set_src(i, 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 16; i++) begin
      bif.sel = 5'(i);
      tick();
      n_cmp++;
      if (i < 6) begin
        if (bif.bus_out !== vals[i] || bif.sel_err !== 1'b0) begin
          n_err++;
          $display("FAIL reg_sel[%0d]: bus_out=%h sel_err=%b, required %h/0",
                   i, bif.bus_out, bif.sel_err, vals[i]);
        end
      end else begin
        if (bif.bus_out !== (32'h1000_0000 + 32'(i)) || bif.sel_err !== 1'b0) begin
          n_err++;
          $display("FAIL reg_sel[%0d]: bus_out=%h sel_err=%b, required %h/0",
                   i, bif.bus_out, bif.sel_err, 32'h1000_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] vals [8];
    vals = '{32'hAAAA_0001, 32'h0000_5555, 32'd7, 32'd8,
             32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_003C, 32'hFFFF_FFF0};
    for (int i = 0; i < 8; i++) set_src(16 + i, vals[i]);
    for (int i = 0; i < 8; i++) begin
      bif.sel = 5'(16 + i);
      tick();
      n_cmp++;
      if (bif.bus_out !== vals[i] || bif.sel_err !== 1'b0) begin
        n_err++;
        $display("FAIL special_sel[%0d]: bus_out=%h sel_err=%b, required %h/0",
                 16 + i, bif.bus_out, bif.sel_err, vals[i]);
      end
    end
  endtask

  task automatic test_unmapped();
    for (int c = 24; c < 32; c++) begin
      bif.sel = 5'(c);
      tick();
      n_cmp++;
      if (bif.bus_out !== 32'd0 || bif.sel_err !== 1'b1) begin
        n_err++;
        $display("FAIL unmapped[%0d]: bus_out=%h sel_err=%b, required 00000000/1",
                 c, bif.bus_out, bif.sel_err);
      end
    end
    bif.sel = 5'd5;
    tick();
    n_cmp++;
    if (bif.bus_out !== 32'd243 || bif.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL unmapped_recover: bus_out=%0d sel_err=%b, required 243/0",
               bif.bus_out, bif.sel_err);
    end
  endtask

  task automatic test_latency();
    bif.sel = 5'd3;
    tick();
    n_cmp++;
    if (bif.bus_out !== 32'd145) begin
      n_err++;
      $display("FAIL latency_pre: bus_out=%0d, required 145", bif.bus_out);
    end
    // Source changes mid-cycle: must not reach bus_out before the next edge.
    #3;
    set_src(3, 32'd77);
    #1;
    n_cmp++;
    if (bif.bus_out !== 32'd145) begin
      n_err++;
      $display("FAIL latency_comb_src: bus_out=%0d, required 145", bif.bus_out);
    end
    tick();
    n_cmp++;
    if (bif.bus_out !== 32'd77) begin
      n_err++;
      $display("FAIL latency_track: bus_out=%0d, required 77", bif.bus_out);
    end
    // Select change mid-cycle: neither output may move before the edge.
    #3;
    bif.sel = 5'd24;
    #1;
    n_cmp++;
    if (bif.bus_out !== 32'd77 || bif.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL latency_comb_sel: bus_out=%0d sel_err=%b, required 77/0",
               bif.bus_out, bif.sel_err);
    end
    tick();
    n_cmp++;
    if (bif.bus_out !== 32'd0 || bif.sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL latency_sel_edge: bus_out=%h sel_err=%b, required 00000000/1",
               bif.bus_out, bif.sel_err);
    end
  endtask

  task automatic test_reset_mid();
    bif.sel = 5'd5;
    tick();
    n_cmp++;
    if (bif.bus_out !== 32'd243) begin
      n_err++;
      $display("FAIL midreset_pre: bus_out=%0d, required 243", bif.bus_out);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++;
    if (bif.bus_out !== 32'd0 || bif.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: bus_out=%h sel_err=%b, required 00000000/0",
               bif.bus_out, bif.sel_err);
    end
    tick();
    n_cmp++;
    if (bif.bus_out !== 32'd243 || bif.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_after: bus_out=%0d sel_err=%b, required 243/0",
               bif.bus_out, bif.sel_err);
    end
    // Clear must also beat an unmapped select.
    bif.sel = 5'd30;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++;
    if (bif.bus_out !== 32'd0 || bif.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL clear_priority: bus_out=%h sel_err=%b, required 00000000/0",
               bif.bus_out, bif.sel_err);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear = 1'b1;
    bif.sel = 5'd0;
    for (int i = 0; i < 24; i++) set_src(i, 32'd0);
    #2;
    test_reset();
    test_registers();
    test_special();
    test_unmapped();
    test_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bus_mux
